fetch_pc_unit: RTL and testbench

Parametrised next-generation program counter for the pipelined core's fetch stage.
- Holds the fetch PC; supports pipeline stall and redirect from the execute stage on mispredict or jump.
- Contains a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches are predicted at fetch with zero bubble.
- Also provides PC+INSTR_BYTES for link-address (JAL/JALR) use downstream.

---
 rtl/fetch_pc_unit_pkg.sv | 20 ++
 rtl/fetch_pc_unit_if.sv | 28 ++
 rtl/fetch_pc_unit_branch_target_buffer.sv | 87 ++++++++
 rtl/fetch_pc_unit.sv | 65 ++++++
 tb/tb_fetch_pc_unit.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and helpers for the fetch PC unit and its branch target buffer.
package fetch_pc_unit_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH  = 32;
    localparam int unsigned DEFAULT_INSTR_BYTES = 4;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] rom_address_t;
    typedef logic [1:0] bp_counter_t;

    localparam bp_counter_t CTR_WEAK_TAKEN = 2'b10;

    function automatic bp_counter_t ctr_inc(input bp_counter_t c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic bp_counter_t ctr_dec(input bp_counter_t c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus: control from the execute stage in, fetch address and prediction out.
interface fetch_pc_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  stall;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  update_valid;
    logic [ADDR_WIDTH-1:0] update_pc;
    logic [ADDR_WIDTH-1:0] update_target;
    logic                  update_taken;
    logic [ADDR_WIDTH-1:0] current_pc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;

    modport master (
        output stall, redirect_valid, redirect_pc,
        output update_valid, update_pc, update_target, update_taken,
        input  current_pc, next_pc, pred_taken, pred_target
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc,
        input  update_valid, update_pc, update_target, update_taken,
        output current_pc, next_pc, pred_taken, pred_target
    );
endinterface

// File: rtl/fetch_pc_unit_branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters; lookup is combinational and
// sees pre-update state when an update hits the same index in the same cycle.
module branch_target_buffer
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned INSTR_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  update_taken
);
    localparam int unsigned OFF  = $clog2(INSTR_BYTES);
    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = ADDR_WIDTH - IDX - OFF;

    logic [BTB_ENTRIES-1:0] valid_r;
    logic [TAGW-1:0]        tag_r    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0]  target_r [BTB_ENTRIES];
    bp_counter_t            ctr_r    [BTB_ENTRIES];

    logic [IDX-1:0]  lk_idx_s;
    logic [TAGW-1:0] lk_tag_s;
    logic [IDX-1:0]  up_idx_s;
    logic [TAGW-1:0] up_tag_s;
    logic            up_hit_s;

    assign lk_idx_s = lookup_pc[IDX+OFF-1:OFF];
    assign lk_tag_s = lookup_pc[ADDR_WIDTH-1:IDX+OFF];
    assign up_idx_s = update_pc[IDX+OFF-1:OFF];
    assign up_tag_s = update_pc[ADDR_WIDTH-1:IDX+OFF];
    assign up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);

    // Instruction-offset bits never take part in indexing or tagging.
    generate
        if (OFF > 0) begin : g_offset
            logic unused_offset_s;
            assign unused_offset_s = ^{lookup_pc[OFF-1:0], update_pc[OFF-1:0]};
        end
    endgenerate

    // Lookup on the fetch address; target is forced to zero unless predicting taken.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = '0;
        if (valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s) && ctr_r[lk_idx_s][1]) begin
            pred_taken  = 1'b1;
            pred_target = target_r[lk_idx_s];
        end else begin
            pred_taken  = 1'b0;
            pred_target = '0;
        end
    end

    // Training: counters saturate on hits, taken misses allocate weakly-taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= '0;
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                tag_r[i]    <= '0;
                target_r[i] <= '0;
                ctr_r[i]    <= 2'b00;
            end
        end else if (update_valid) begin
            if (up_hit_s) begin
                if (update_taken) begin
                    ctr_r[up_idx_s]    <= ctr_inc(ctr_r[up_idx_s]);
                    target_r[up_idx_s] <= update_target;
                end else begin
                    ctr_r[up_idx_s] <= ctr_dec(ctr_r[up_idx_s]);
                end
            end else if (update_taken) begin
                valid_r[up_idx_s]  <= 1'b1;
                tag_r[up_idx_s]    <= up_tag_s;
                target_r[up_idx_s] <= update_target;
                ctr_r[up_idx_s]    <= CTR_WEAK_TAKEN;
            end
        end
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch program counter: redirect > stall > predicted target > sequential.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int unsigned           BTB_ENTRIES = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned           INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
    input  logic            clk,
    input  logic            reset,
    fetch_pc_unit_if.slave  bus
);
    logic [ADDR_WIDTH-1:0] current_pc_r;
    logic [ADDR_WIDTH-1:0] next_pc_s;
    logic [ADDR_WIDTH-1:0] pc_d_s;
    logic                  pred_taken_s;
    logic [ADDR_WIDTH-1:0] pred_target_s;

    assign next_pc_s = current_pc_r + ADDR_WIDTH'(INSTR_BYTES);

    branch_target_buffer #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_btb (
        .clk           (clk),
        .reset         (reset),
        .lookup_pc     (current_pc_r),
        .pred_taken    (pred_taken_s),
        .pred_target   (pred_target_s),
        .update_valid  (bus.update_valid),
        .update_pc     (bus.update_pc),
        .update_target (bus.update_target),
        .update_taken  (bus.update_taken)
    );

    // Next fetch address selection.
    always_comb begin
        pc_d_s = next_pc_s;
        if (bus.redirect_valid) begin
            pc_d_s = bus.redirect_pc;
        end else if (bus.stall) begin
            pc_d_s = current_pc_r;
        end else if (pred_taken_s) begin
            pc_d_s = pred_target_s;
        end else begin
            pc_d_s = next_pc_s;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current_pc_r <= RESET_PC;
        end else begin
            current_pc_r <= pc_d_s;
        end
    end

    assign bus.current_pc  = current_pc_r;
    assign bus.next_pc     = next_pc_s;
    assign bus.pred_taken  = pred_taken_s;
    assign bus.pred_target = pred_target_s;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed scoreboard bench for fetch_pc_unit: two instances (RESET_PC 0 and 0xFFFFFFFC).
module tb_fetch_pc_unit;
    logic clk = 1'b0;
    logic reset_a = 1'b0;
    logic reset_b = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    always #5 clk = ~clk;

    fetch_pc_unit_if #(.ADDR_WIDTH(32)) ifa ();
    fetch_pc_unit_if #(.ADDR_WIDTH(32)) ifb ();

    fetch_pc_unit #(.ADDR_WIDTH(32), .BTB_ENTRIES(16), .RESET_PC(32'h0000_0000), .INSTR_BYTES(4))
        dut_a (.clk(clk), .reset(reset_a), .bus(ifa));
    fetch_pc_unit #(.ADDR_WIDTH(32), .BTB_ENTRIES(16), .RESET_PC(32'hFFFF_FFFC), .INSTR_BYTES(4))
        dut_b (.clk(clk), .reset(reset_b), .bus(ifb));

    typedef struct {
        bit          sel;
        int          id;
        logic [31:0] cur;
        logic [31:0] nxt;
        logic        pt;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input int id, input string what, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step %0d %s got %h expected %h", id, what, got, want);
        end
    endtask

    // Monitor: one expectation per observed cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.sel) begin
                chk(e.id, "b.current_pc",  ifb.current_pc,         e.cur);
                chk(e.id, "b.next_pc",     ifb.next_pc,            e.nxt);
                chk(e.id, "b.pred_taken",  {31'd0, ifb.pred_taken}, {31'd0, e.pt});
                chk(e.id, "b.pred_target", ifb.pred_target,        e.tgt);
            end else begin
                chk(e.id, "a.current_pc",  ifa.current_pc,         e.cur);
                chk(e.id, "a.next_pc",     ifa.next_pc,            e.nxt);
                chk(e.id, "a.pred_taken",  {31'd0, ifa.pred_taken}, {31'd0, e.pt});
                chk(e.id, "a.pred_target", ifa.pred_target,        e.tgt);
            end
        end
    end

    task automatic push_exp(input bit sel, input logic [31:0] ecur, input logic ept, input logic [31:0] etgt);
        exp_t e;
        e.sel = sel;
        e.id  = step_id;
        e.cur = ecur;
        e.nxt = ecur + 32'd4;
        e.pt  = ept;
        e.tgt = etgt;
        exp_q.push_back(e);
        step_id++;
    endtask

    task automatic drive(input bit sel, input logic st, input logic rv, input logic [31:0] rpc,
                         input logic uv, input logic [31:0] upc, input logic [31:0] utgt, input logic ut);
        ifa.stall = 1'b0; ifa.redirect_valid = 1'b0; ifa.redirect_pc = 32'd0;
        ifa.update_valid = 1'b0; ifa.update_pc = 32'd0; ifa.update_target = 32'd0; ifa.update_taken = 1'b0;
        ifb.stall = 1'b0; ifb.redirect_valid = 1'b0; ifb.redirect_pc = 32'd0;
        ifb.update_valid = 1'b0; ifb.update_pc = 32'd0; ifb.update_target = 32'd0; ifb.update_taken = 1'b0;
        if (sel) begin
            ifb.stall = st; ifb.redirect_valid = rv; ifb.redirect_pc = rpc;
            ifb.update_valid = uv; ifb.update_pc = upc; ifb.update_target = utgt; ifb.update_taken = ut;
        end else begin
            ifa.stall = st; ifa.redirect_valid = rv; ifa.redirect_pc = rpc;
            ifa.update_valid = uv; ifa.update_pc = upc; ifa.update_target = utgt; ifa.update_taken = ut;
        end
    endtask

    // One cycle: expected outputs for this cycle, inputs acting at the coming edge.
    task automatic step(input bit sel, input logic st, input logic rv, input logic [31:0] rpc,
                        input logic uv, input logic [31:0] upc, input logic [31:0] utgt, input logic ut,
                        input logic [31:0] ecur, input logic ept, input logic [31:0] etgt);
        push_exp(sel, ecur, ept, etgt);
        drive(sel, st, rv, rpc, uv, upc, utgt, ut);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        // Held in reset: PC at RESET_PC, nothing predicted.
        step(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h00, 0, 32'h0);
        reset_a = 1'b1;
        // Sequential fetch.
        step(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h00, 0, 32'h0);
        step(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h04, 0, 32'h0);
        step(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h08, 0, 32'h0);
        step(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h0C, 0, 32'h0);
        step(0, 0, 1, 32'h8,  0, 32'h0,  32'h0,  0, 32'h10, 0, 32'h0);
        // Stall holds; redirect overrides stall.
        step(0, 1, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h08, 0, 32'h0);
        step(0, 1, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h08, 0, 32'h0);
        step(0, 1, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h08, 0, 32'h0);
        step(0, 1, 1, 32'h40, 0, 32'h0,  32'h0,  0, 32'h08, 0, 32'h0);
        step(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h40, 0, 32'h0);
        // Loop training at 0x10 -> 0x8.
        step(0, 0, 0, 32'h0,  1, 32'h10, 32'h8,  1, 32'h44, 0, 32'h0);
        step(0, 0, 1, 32'h10, 0, 32'h0,  32'h0,  0, 32'h48, 0, 32'h0);
        step(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h10, 1, 32'h8);
        step(0, 0, 0, 32'h0,  1, 32'h10, 32'h0,  0, 32'h08, 0, 32'h0);
        step(0, 0, 0, 32'h0,  1, 32'h10, 32'h0,  0, 32'h0C, 0, 32'h0);
        step(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h10, 0, 32'h0);
        // Retrain 0x10 (counter 0 -> 1 -> 2), then alias at 0x50.
        step(0, 0, 0, 32'h0,  1, 32'h10, 32'h8,  1, 32'h14, 0, 32'h0);
        step(0, 0, 0, 32'h0,  1, 32'h10, 32'h8,  1, 32'h18, 0, 32'h0);
        step(0, 0, 1, 32'h50, 0, 32'h0,  32'h0,  0, 32'h1C, 0, 32'h0);
        step(0, 0, 0, 32'h0,  1, 32'h50, 32'h80, 1, 32'h50, 0, 32'h0);
        step(0, 0, 1, 32'h10, 0, 32'h0,  32'h0,  0, 32'h54, 0, 32'h0);
        step(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h10, 0, 32'h0);
        step(0, 0, 1, 32'h50, 0, 32'h0,  32'h0,  0, 32'h14, 0, 32'h0);
        step(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h50, 1, 32'h80);
        // Re-allocate 0x10; redirect beats a live prediction.
        step(0, 0, 0, 32'h0,  1, 32'h10, 32'h8,  1, 32'h80, 0, 32'h0);
        step(0, 0, 1, 32'h10, 0, 32'h0,  32'h0,  0, 32'h84, 0, 32'h0);
        step(0, 0, 1, 32'h20, 0, 32'h0,  32'h0,  0, 32'h10, 1, 32'h8);
        // Asynchronous reset between edges at 0x20.
        push_exp(0, 32'h20, 0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        #2;
        reset_a = 1'b0;
        #1;
        chk(-1, "async_reset.current_pc", ifa.current_pc, 32'h0);
        chk(-1, "async_reset.pred_taken", {31'd0, ifa.pred_taken}, 32'd0);
        @(posedge clk);
        #1;
        step(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h00, 0, 32'h0);
        reset_a = 1'b1;
        step(0, 0, 1, 32'h10, 0, 32'h0,  32'h0,  0, 32'h00, 0, 32'h0);
        step(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h10, 0, 32'h0);
        step(0, 0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h14, 0, 32'h0);
        // Wrap-around and same-cycle update/lookup on the second instance.
        reset_b = 1'b1;
        step(1, 0, 0, 32'h0,  0, 32'h0,  32'h0,   0, 32'hFFFF_FFFC, 0, 32'h0);
        step(1, 0, 0, 32'h0,  1, 32'h0,  32'h100, 1, 32'h0000_0000, 0, 32'h0);
        step(1, 0, 1, 32'h0,  0, 32'h0,  32'h0,   0, 32'h0000_0004, 0, 32'h0);
        step(1, 0, 0, 32'h0,  0, 32'h0,  32'h0,   0, 32'h0000_0000, 1, 32'h100);
        step(1, 0, 0, 32'h0,  0, 32'h0,  32'h0,   0, 32'h0000_0100, 0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
